multicycle_core: RTL and testbench
==================================

// Module: multicycle_core
// PURPOSE
// Parametrised multicycle successor of the 9-bit single-cycle processor top. It holds its own PC, an 8-entry
// register file, the ALU and a fetch/execute/memory FSM. Instruction ROM and data memory sit outside the core.
// Both are synchronous-read with 1-cycle latency. Adds a Start/Ack run handshake, a cycle counter and a watchdog timeout.
// PARAMETERS
// DW        8     data/register width (>=4)
// PCW       10    program counter width; PC arithmetic is mod 2^PCW
// START_PC  0     PC loaded on accepted Start
// CW        16    cycle counter width
// MAX_CYC   0     watchdog limit in run cycles; 0 = disabled
// PORTS
// Clk         in   1     clock, posedge
// Reset       in   1     synchronous, active-high
// Start       in   1     begin run; sampled only in IDLE or DONE
// Ack         out  1     run finished (HALT or timeout); held until next accepted Start
// Timeout     out  1     run ended by watchdog; valid while Ack=1
// imem_addr   out  PCW   instruction address (= PC)
// imem_data   in   9     instruction; valid the cycle after imem_addr
// dmem_addr   out  DW    data address (= R[rb])
// dmem_wdata  out  DW    store data (= R[ra])
// dmem_we     out  1     store strobe, one cycle
// dmem_rdata  in   DW    load data; valid the cycle after dmem_addr
// cycle_ct    out  CW    run cycles counted in FETCH/EXEC/MEMRD; saturates at all-ones
// BEHAVIOUR
// Reset: state=IDLE; PC=START_PC; R0..R7=0; Ack=0; Timeout=0; cycle_ct=0. dmem_we is gated by !Reset.
// A store whose EXEC cycle coincides with Reset does not write.
// ISA: op=I[8:6], ra=I[5:3], rb=I[2:0].
//   000 ADD ra+=rb | 001 SUB ra-=rb | 010 AND | 011 XOR  (results mod 2^DW)
//   100 LD R[ra]<=mem[R[rb]] | 101 ST mem[R[rb]]<=R[ra]
//   110 BNZ: if R[ra]!=0 then PC<=PC+sext(R[rb]) (DW->PCW), else PC+1
//   111 SHI: R[ra]<={R[ra][DW-4:0],rb}. The encoding 9'h1FF is HALT (SHI R7,7 does not exist).
// States:
//   IDLE: Start -> FETCH. PC<=START_PC, cycle_ct<=0, Ack<=0, Timeout<=0.
//   FETCH: imem_addr=PC -> EXEC.
//   EXEC: decodes imem_data.
//     ALU/SHI/BNZ/ST: update RF/PC, dmem_we=1 for ST -> FETCH.
//     LD: latch ra, drive dmem_addr -> MEMRD.
//     HALT: PC held -> DONE.
//   MEMRD: R[ra_latched]<=dmem_rdata, PC+1 -> FETCH.
//   DONE: Ack=1. Start -> FETCH with the same actions as IDLE. Registers are preserved across runs.
// Latency: ALU/SHI/BNZ/ST/HALT take 2 cycles, LD takes 3.
// Start sampled in IDLE at cycle N: FETCH at N+1, first EXEC at N+2.
// Start during FETCH/EXEC/MEMRD is ignored.
// PC+1 and branch targets wrap mod 2^PCW. BNZ with R[rb]=0 and R[ra]!=0 is a tight loop at the same PC.
// Watchdog: if MAX_CYC!=0 and cycle_ct reaches MAX_CYC at a cycle edge -> DONE, Timeout=1, Ack=1.
//   Any in-flight LD is dropped with no RF write. Watchdog beats HALT if both happen on the same edge.
// Ack and Timeout are registered. The first Ack=1 cycle is the DONE cycle.
// TESTING
// T1 ALU+store: ROM = SHI r1,5 (1CD); SHI r2,3 (1D3); ADD r1,r2 (00A); ST r1,r2 (14A); HALT. Start at N.
//    -> mem[3]=8, Ack rises at N+11, cycle_ct=10, Timeout=0.
// T2 load latency: ST r1->mem[3], then LD r4,[r2]. LD holds EXEC and MEMRD; dmem_addr=3 in EXEC.
//    -> r4=8, confirmed by a follow-up store. LD adds exactly 1 cycle to cycle_ct vs a store.
// T3 loop: r1=3, r7=-1 via SHIs, decrement and BNZ back.
//    -> body runs 3 times, falls through, HALT. Ack=1. Exact cycle_ct matches 2/3-cycle rule.
// T4 watchdog: MAX_CYC=20, ROM = SHI r1,1; BNZ r1,r0 (self-loop).
//    -> Ack=1 and Timeout=1 when cycle_ct=20. Start again clears Timeout and reruns.
// T5 wrap: PCW=4, START_PC=15, ROM[15]=ADD, ROM[0]=HALT.
//    -> PC wraps 15->0 and Ack=1. Branch of -2 from PC 0 lands at 14.
// T6 Reset mid-run: assert Reset in the EXEC cycle of an ST.
//    -> dmem_we=0, memory unchanged. Next cycle: IDLE, Ack=0, cycle_ct=0, all regs 0. Start while busy is ignored.

Source files
------------

// File: rtl/multicycle_core.sv
// Multicycle core for the 9-bit ISA: PC, 8-entry register file, ALU and fetch/exec/memory FSM.
// Instruction ROM and data memory are external, both synchronous-read with one cycle of latency.
module multicycle_core #(
  parameter int unsigned DW       = 8,
  parameter int unsigned PCW      = 10,
  parameter int unsigned START_PC = 0,
  parameter int unsigned CW       = 16,
  parameter int unsigned MAX_CYC  = 0
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  output logic           Ack,
  output logic           Timeout,
  output logic [PCW-1:0] imem_addr,
  input  logic [8:0]     imem_data,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  output logic           dmem_we,
  input  logic [DW-1:0]  dmem_rdata,
  output logic [CW-1:0]  cycle_ct
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_BNZ = 3'd6;
  localparam logic [2:0] OP_SHI = 3'd7;
  localparam logic [8:0] HALT   = 9'h1FF;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEMRD, S_DONE} state_t;

  state_t         state;
  logic [PCW-1:0] pc;
  logic [DW-1:0]  rf [8];
  logic [2:0]     ra_q;

  logic [2:0]     op;
  logic [2:0]     ra;
  logic [2:0]     rb;
  logic [DW-1:0]  rv_a;
  logic [DW-1:0]  rv_b;
  logic [PCW-1:0] br_off;
  logic [CW-1:0]  cyc_inc;
  logic           running;
  logic           wdog;

  assign op      = imem_data[8:6];
  assign ra      = imem_data[5:3];
  assign rb      = imem_data[2:0];
  assign rv_a    = rf[ra];
  assign rv_b    = rf[rb];
  assign br_off  = PCW'($signed(rv_b));
  assign cyc_inc = (&cycle_ct) ? cycle_ct : cycle_ct + CW'(1);
  assign running = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEMRD);
  // Watchdog fires on the edge where the saturating run counter reaches the limit.
  assign wdog    = (MAX_CYC != 0) && running && (cyc_inc == CW'(MAX_CYC));

  assign imem_addr  = pc;
  assign dmem_addr  = rv_b;
  assign dmem_wdata = rv_a;
  assign dmem_we    = (state == S_EXEC) && (op == OP_ST) && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc       <= PCW'(START_PC);
      ra_q     <= 3'd0;
      Ack      <= 1'b0;
      Timeout  <= 1'b0;
      cycle_ct <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state    <= S_FETCH;
            pc       <= PCW'(START_PC);
            cycle_ct <= '0;
            Ack      <= 1'b0;
            Timeout  <= 1'b0;
          end
        end
        S_FETCH: begin
          cycle_ct <= cyc_inc;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          cycle_ct <= cyc_inc;
          state    <= S_FETCH;
          if (imem_data == HALT) begin
            state <= S_DONE;
            Ack   <= 1'b1;
          end else begin
            pc <= pc + PCW'(1);
            case (op)
              OP_ADD: rf[ra] <= rv_a + rv_b;
              OP_SUB: rf[ra] <= rv_a - rv_b;
              OP_AND: rf[ra] <= rv_a & rv_b;
              OP_XOR: rf[ra] <= rv_a ^ rv_b;
              OP_LD: begin
                ra_q  <= ra;
                pc    <= pc;
                state <= S_MEMRD;
              end
              OP_BNZ: if (rv_a != '0) pc <= pc + br_off;
              OP_SHI: rf[ra] <= {rv_a[DW-4:0], rb};
              default: ;
            endcase
          end
        end
        S_MEMRD: begin
          cycle_ct <= cyc_inc;
          state    <= S_FETCH;
          // A load caught by the watchdog is dropped without touching the register file.
          if (!wdog) begin
            rf[ra_q] <= dmem_rdata;
            pc       <= pc + PCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (wdog) begin
        state   <= S_DONE;
        Ack     <= 1'b1;
        Timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed ISA, latency, loop, wrap, watchdog and reset sequences,
// plus random straight-line programs checked against an instruction-level reference model.
module tb_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, start_a, start_b, mem_clr;
  logic        ack_a, to_a, we_a;
  logic [9:0]  ia_a;
  logic [8:0]  id_a;
  logic [7:0]  da_a, dw_a, dr_a;
  logic [15:0] cyc_a;
  logic        ack_b, to_b, we_b;
  logic [3:0]  ia_b;
  logic [8:0]  id_b;
  logic [7:0]  da_b, dw_b;
  logic [15:0] cyc_b;

  multicycle_core u_a (
    .Clk(clk), .Reset(rst_a), .Start(start_a), .Ack(ack_a), .Timeout(to_a),
    .imem_addr(ia_a), .imem_data(id_a), .dmem_addr(da_a), .dmem_wdata(dw_a),
    .dmem_we(we_a), .dmem_rdata(dr_a), .cycle_ct(cyc_a)
  );

  multicycle_core #(.PCW(4), .START_PC(15), .MAX_CYC(20)) u_b (
    .Clk(clk), .Reset(rst_b), .Start(start_b), .Ack(ack_b), .Timeout(to_b),
    .imem_addr(ia_b), .imem_data(id_b), .dmem_addr(da_b), .dmem_wdata(dw_b),
    .dmem_we(we_b), .dmem_rdata(8'h00), .cycle_ct(cyc_b)
  );

  logic [8:0]  rom_a [1024];
  logic [8:0]  rom_b [16];
  logic [7:0]  mem_a [256];
  logic [15:0] st_q [$];

  // Synchronous ROMs / data memory, plus a log of every store the core issues.
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
    else if (we_a) mem_a[da_a] <= dw_a;
    if (we_a) st_q.push_back({da_a, dw_a});
    dr_a <= mem_a[da_a];
    id_a <= rom_a[ia_a];
    id_b <= rom_b[ia_b];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state and instruction-level execution.
  int          m_rf [8];
  int          m_mem [256];
  logic [15:0] exp_q [$];
  int          exp_cyc;
  logic [8:0]  prog [$];

  task automatic model_run();
    int pc, op, ra, rb, a, b, off;
    logic [8:0] ins;
    pc = 0;
    exp_cyc = 0;
    exp_q.delete();
    for (int s = 0; s < 2000; s++) begin
      ins = rom_a[pc];
      if (ins == 9'h1FF) begin
        exp_cyc += 2;
        break;
      end
      op = int'(ins[8:6]);
      ra = int'(ins[5:3]);
      rb = int'(ins[2:0]);
      a  = m_rf[ra];
      b  = m_rf[rb];
      pc = (pc + 1) % 1024;
      exp_cyc += (op == 4) ? 3 : 2;
      case (op)
        0: m_rf[ra] = (a + b) % 256;
        1: m_rf[ra] = (a - b + 256) % 256;
        2: m_rf[ra] = a & b;
        3: m_rf[ra] = a ^ b;
        4: m_rf[ra] = m_mem[b];
        5: begin
          m_mem[b] = a;
          exp_q.push_back(16'(b * 256 + a));
        end
        6: if (a != 0) begin
          off = (b >= 128) ? b - 256 : b;
          pc  = (pc - 1 + off + 1024) % 1024;
        end
        default: m_rf[ra] = (a * 8 + rb) % 256;
      endcase
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) rom_a[i] = prog[i];
  endtask

  int tr_i [64];
  int tr_d [64];
  int tr_w [64];

  // Start a run on instance 0 (main) or 1 (small), optionally pulse Start mid-run, wait for Ack.
  task automatic run(input int inst, input string nm, input int pulse_at, output int lat);
    int n;
    @(negedge clk);
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    n = 1;
    while (n < 3000 && !((inst == 0) ? ack_a : ack_b)) begin
      if (n < 64) begin
        tr_i[n] = (inst == 0) ? int'(ia_a) : int'(ia_b);
        tr_d[n] = int'(da_a);
        tr_w[n] = int'(we_a);
      end
      if (inst == 0) start_a = (n == pulse_at); else start_b = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk({nm, "_ack"}, (inst == 0) ? ack_a : ack_b, 1);
    lat = n;
  endtask

  task automatic cmp_stores(input string nm, input int base);
    chk({nm, "_nstores"}, st_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < st_q.size(); i++)
      chk($sformatf("%s_store%0d", nm, i), st_q[base + i], exp_q[i]);
  endtask

  typedef struct {
    int               n;
    logic [4:0][12:0] ent;   // {rom address, instruction}
    int               lat;
    int               cyc;
    logic             to;
    int               pc;
  } vec_t;

  vec_t       vt [4];
  int         lat, base, len, addr, snap;
  logic [31:0] r;
  logic [2:0] op;
  logic [8:0] ins;

  initial begin
    vt[0] = '{2, {13'h0, 13'h0, 13'h0, {4'd0, 9'h1FF}, {4'd15, 9'h000}}, 5, 4, 1'b0, 0};
    vt[1] = '{5, {{4'd3, 9'h1FF}, {4'd2, 9'h1C9}, {4'd1, 9'h1D6}, {4'd0, 9'h1D7}, {4'd15, 9'h1D7}},
              11, 10, 1'b0, 3};
    vt[2] = '{3, {13'h0, 13'h0, {4'd14, 9'h1FF}, {4'd0, 9'h18A}, {4'd15, 9'h000}}, 7, 6, 1'b0, 14};
    vt[3] = '{2, {13'h0, 13'h0, 13'h0, {4'd0, 9'h188}, {4'd15, 9'h1C9}}, 21, 20, 1'b1, 0};

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < 1024; i++) rom_a[i] = 9'h1FF;
    for (int i = 0; i < 16; i++) rom_b[i] = 9'h1FF;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack_a, 0);
    chk("rst_timeout", to_a, 0);
    chk("rst_cycle_ct", cyc_a, 0);
    chk("rst_pc", ia_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_pc_small", ia_b, 15);
    chk("rst_ack_small", ack_b, 0);

    // Small core: PC wrap, negative branch across zero, watchdog.
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < vt[v].n; j++) rom_b[vt[v].ent[j][12:9]] = vt[v].ent[j][8:0];
      run(1, $sformatf("vec%0d", v), 0, lat);
      chk($sformatf("vec%0d_latency", v), lat, vt[v].lat);
      chk($sformatf("vec%0d_cycle_ct", v), cyc_b, vt[v].cyc);
      chk($sformatf("vec%0d_timeout", v), to_b, vt[v].to);
      chk($sformatf("vec%0d_pc", v), ia_b, vt[v].pc);
      if (v == 0) chk("wrap_pc_after_15", tr_i[3], 0);
      if (v == 2) chk("branch_back_to_14", tr_i[5], 14);
    end
    chk("small_no_store", we_b, 0);

    // Restart after a watchdog timeout clears Timeout and reruns into the watchdog again.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("wd_restart_timeout", to_b, 0);
    chk("wd_restart_ack", ack_b, 0);
    chk("wd_restart_cycle_ct", cyc_b, 0);
    lat = 1;
    while (!ack_b && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("wd_rerun_ack", ack_b, 1);
    chk("wd_rerun_timeout", to_b, 1);
    chk("wd_rerun_cycle_ct", cyc_b, 20);
    chk("wd_rerun_latency", lat, 21);

    // T1: ALU + store, with a Start pulse while busy that must be ignored.
    prog = '{9'h1CD, 9'h1D3, 9'h00A, 9'h14A, 9'h1FF};
    load_prog(); model_run();
    exp_q = '{16'h0308};
    base = st_q.size();
    run(0, "t1", 4, lat);
    chk("t1_latency", lat, 11);
    chk("t1_cycle_ct", cyc_a, 10);
    chk("t1_timeout", to_a, 0);
    chk("t1_mem3", mem_a[3], 8);
    cmp_stores("t1", base);

    // T2: load latency and data path.
    prog = '{9'h14A, 9'h122, 9'h160, 9'h1FF};
    load_prog(); model_run();
    exp_q = '{16'h0308, 16'h0008};
    base = st_q.size();
    run(0, "t2", 0, lat);
    chk("t2_latency", lat, 10);
    chk("t2_cycle_ct", cyc_a, 9);
    chk("t2_ld_addr", tr_d[4], 3);
    chk("t2_ld_no_we", tr_w[4], 0);
    chk("t2_st_we", tr_w[2], 1);
    cmp_stores("t2", base);

    // T3: countdown loop with BNZ back by -1.
    prog = '{9'h0C9, 9'h1CB, 9'h0ED, 9'h1E9, 9'h0FF, 9'h07D, 9'h00F, 9'h18F,
             9'h149, 9'h17F, 9'h1FF};
    load_prog(); model_run();
    exp_q = '{16'h0000, 16'hFFFF};
    base = st_q.size();
    run(0, "t3", 0, lat);
    chk("t3_latency", lat, 31);
    chk("t3_cycle_ct", cyc_a, 30);
    chk("t3_timeout", to_a, 0);
    cmp_stores("t3", base);

    // Random straight-line programs ending in a register dump.
    for (int t = 0; t < 20; t++) begin
      len = int'($urandom_range(8, 24));
      prog.delete();
      for (int i = 0; i < len; i++) begin
        r = $urandom;
        op = r[11:9];
        if (op == 3'd6) op = 3'd4;
        ins = {op, r[5:0]};
        if (ins == 9'h1FF) ins = 9'h1FE;
        prog.push_back(ins);
      end
      for (int i = 0; i < 8; i++) prog.push_back({3'b101, 3'(i), 3'(i)});
      prog.push_back(9'h1FF);
      load_prog(); model_run();
      base = st_q.size();
      run(0, $sformatf("rnd%0d", t), 0, lat);
      chk($sformatf("rnd%0d_latency", t), lat, exp_cyc + 1);
      chk($sformatf("rnd%0d_cycle_ct", t), cyc_a, exp_cyc);
      chk($sformatf("rnd%0d_timeout", t), to_a, 0);
      cmp_stores($sformatf("rnd%0d", t), base);
    end

    // T6: Reset in the EXEC cycle of a store.
    addr = m_rf[7];
    snap = m_mem[addr];
    rom_a[0] = 9'h16F;
    base = st_q.size();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    chk("t6_we_before_reset", we_a, 1);
    rst_a = 1'b1;
    #1;
    chk("t6_we_gated", we_a, 0);
    @(negedge clk);
    chk("t6_ack", ack_a, 0);
    chk("t6_cycle_ct", cyc_a, 0);
    chk("t6_pc", ia_a, 0);
    chk("t6_timeout", to_a, 0);
    chk("t6_mem_kept", mem_a[addr], snap);
    chk("t6_no_store", st_q.size() - base, 0);
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back({3'b101, 3'(i), 3'(i)});
    prog.push_back(9'h1FF);
    load_prog(); model_run();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0000);
    base = st_q.size();
    run(0, "t6_dump", 0, lat);
    chk("t6_dump_latency", lat, 19);
    chk("t6_dump_cycle_ct", cyc_a, 18);
    cmp_stores("t6_dump", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
